// File: rtl/hotp_truncate.sv
// hotp_truncate: HOTP/TOTP dynamic truncation and decimal conversion.
//
// Takes a finished HMAC digest one byte per cycle, byte 0 first. It applies
// RFC 4226 dynamic truncation to get a 31-bit word P. A 31-step double-dabble
// pass turns P into ten BCD digits. The low DIGITS digits are then held for
// random-access readout.
//
// Parameters:
//   HASH_BYTES  digest length in bytes (20, 32 or 64)
//   DIGITS      code length in decimal digits (1..10)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   restart    synchronous abort; acts like reset and blocks a concurrent byte
//   in_valid   digest byte present on in_data
//   in_data    digest byte
//   in_ready   a byte is accepted this cycle when in_valid is also high
//   out_valid  code is complete and stable
//   digit_sel  digit index, 0 = least significant
//   bcd        selected digit, 4'hF when blanked
//   segs       seven-segment pattern (gfedcba, active-high) of the selected digit
//
// Build option: define HOTP_TRUNC_SEGS_EN to include the seven-segment
// decoder. Without it, segs is tied to zero.

module hotp_truncate #(
  parameter int HASH_BYTES = 20,
  parameter int DIGITS     = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       restart,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  input  logic [3:0] digit_sel,
  output logic [3:0] bcd,
  output logic [6:0] segs
);

  typedef enum logic [1:0] {ST_LOAD, ST_TRUNC, ST_CONV, ST_DONE} state_t;

  localparam int         BUF_W      = HASH_BYTES * 8;
  localparam logic [6:0] LAST_BYTE  = 7'(HASH_BYTES - 1);
  localparam logic [6:0] LAST_SHIFT = 7'd30;

  state_t             state_q;
  logic [6:0]         cnt_q;
  logic [BUF_W-1:0]   hbuf_q;
  logic [30:0]        p_q;
  logic [39:0]        dd_q;
  logic               rdy_q;
  logic               vld_q;
  logic [39:0]        dd_adj;

  // Dynamic truncation. The buffer shifts downward, so byte k ends up at
  // bits [8k +: 8]. The offset comes from the low nibble of the last byte.
  function automatic logic [30:0] trunc_word(input logic [BUF_W-1:0] b);
    logic [3:0]  off;
    logic [31:0] w;
    off = b[BUF_W-8 +: 4];
    w   = '0;
    for (int i = 0; i < 16; i++) begin
      if (off == 4'(i))
        w = {b[i*8 +: 8], b[(i+1)*8 +: 8], b[(i+2)*8 +: 8], b[(i+3)*8 +: 8]};
    end
    return w[30:0];
  endfunction

  // Double-dabble correction: any BCD digit >= 5 gets +3 before the shift.
  function automatic logic [39:0] dd_add3(input logic [39:0] v);
    logic [39:0] r;
    r = v;
    for (int d = 0; d < 10; d++) begin
      if (v[d*4 +: 4] >= 4'd5)
        r[d*4 +: 4] = v[d*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign dd_adj    = dd_add3(dd_q);
  assign in_ready  = rdy_q & ~restart;
  assign out_valid = vld_q;

  always_ff @(posedge clk) begin
    if (!rst_n || restart) begin
      state_q <= ST_LOAD;
      cnt_q   <= '0;
      dd_q    <= '0;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
    end else begin
      case (state_q)
        // Byte load stage
        ST_LOAD: begin
          if (in_valid) begin
            hbuf_q <= {in_data, hbuf_q[BUF_W-1:8]};
            if (cnt_q == LAST_BYTE) begin
              state_q <= ST_TRUNC;
              cnt_q   <= '0;
              rdy_q   <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 7'd1;
            end
          end
        end
        // Truncation stage
        ST_TRUNC: begin
          p_q     <= trunc_word(hbuf_q);
          dd_q    <= '0;
          cnt_q   <= '0;
          state_q <= ST_CONV;
        end
        // Binary-to-BCD stage: one bit of P per cycle, MSB first
        ST_CONV: begin
          dd_q <= {dd_adj[38:0], p_q[30]};
          p_q  <= {p_q[29:0], 1'b0};
          if (cnt_q == LAST_SHIFT) begin
            state_q <= ST_DONE;
            cnt_q   <= '0;
            rdy_q   <= 1'b1;
            vld_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 7'd1;
          end
        end
        // Result hold stage. A new byte starts the next digest as byte 0.
        ST_DONE: begin
          if (in_valid) begin
            hbuf_q  <= {in_data, hbuf_q[BUF_W-1:8]};
            cnt_q   <= 7'd1;
            state_q <= ST_LOAD;
            vld_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_LOAD;
          cnt_q   <= '0;
          rdy_q   <= 1'b1;
          vld_q   <= 1'b0;
        end
      endcase
    end
  end

  // Readout. Digits above DIGITS and any digit without a valid result read as blank.
  always_comb begin
    bcd = 4'hF;
    if (vld_q) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (digit_sel == 4'(i))
          bcd = dd_q[i*4 +: 4];
      end
    end
  end

`ifdef HOTP_TRUNC_SEGS_EN
  always_comb begin
    case (bcd)
      4'd0:    segs = 7'h3F;
      4'd1:    segs = 7'h06;
      4'd2:    segs = 7'h5B;
      4'd3:    segs = 7'h4F;
      4'd4:    segs = 7'h66;
      4'd5:    segs = 7'h6D;
      4'd6:    segs = 7'h7D;
      4'd7:    segs = 7'h07;
      4'd8:    segs = 7'h7F;
      4'd9:    segs = 7'h6F;
      default: segs = 7'h00;
    endcase
  end
`else
  assign segs = 7'h00;
`endif

endmodule
